// File: rtl/booth_seq_mult.sv
// Sequential radix-2 Booth multiplier for signed two's-complement operands.
// Performs one add/subtract/no-op step plus an arithmetic right shift of
// {A,Q,q_m1} per clock. The A-register adder is built from 4-bit carry-lookahead
// groups, and carries ripple between groups.
//
// Ports:
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   start        request, sampled only in IDLE
//   clear        synchronous abort: returns to IDLE with no done pulse
//   multiplicand signed operand M, sampled with start
//   multiplier   signed operand Q, sampled with start
//   busy         high while an operation is in progress
//   done         one-cycle completion pulse
//   product      signed 2*WIDTH result, held until the next completion
module booth_seq_mult #(
    parameter int unsigned WIDTH = 8    // multiple of 4, at least 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 clear,
    input  logic [WIDTH-1:0]     multiplicand,
    input  logic [WIDTH-1:0]     multiplier,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);

    localparam int unsigned AW   = WIDTH + 1;            // A and M width
    localparam int unsigned CW   = $clog2(WIDTH) + 1;    // step counter width
    localparam int unsigned NGRP = WIDTH / 4;            // lookahead groups

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_e;

    state_e               state_q, state_d;
    logic [AW-1:0]        a_q, a_d;
    logic [WIDTH-1:0]     q_q, q_d;
    logic                 qm1_q, qm1_d;
    logic [AW-1:0]        m_q, m_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic [2*WIDTH-1:0]   prod_q, prod_d;

    // Adder operands: {Q[0],q_m1}=10 subtracts via ~M with carry-in 1.
    logic                 add_sub;
    logic [AW-1:0]        add_a;
    logic [AW-1:0]        add_b;
    logic [AW-1:0]        add_p;
    logic [WIDTH-1:0]     add_g;
    logic [AW-1:0]        add_sum;

    assign add_sub = q_q[0];
    assign add_a   = a_q;
    assign add_b   = add_sub ? ~m_q : m_q;
    assign add_p   = add_a ^ add_b;
    // Generate of the very top bit would only feed the discarded carry-out.
    assign add_g   = add_a[WIDTH-1:0] & add_b[WIDTH-1:0];

    // Carry-lookahead groups; the top group is 5 bits wide to cover the extra A bit.
    for (genvar gi = 0; gi < NGRP; gi++) begin : g_grp
        localparam int unsigned BASE = gi * 4;
        localparam int unsigned GSZ  = (gi == NGRP - 1) ? 5 : 4;

        logic       cin_g;
        logic [3:0] cyv;    // carry out of each of the low four bits

        if (gi == 0) begin : g_first
            assign cin_g = add_sub;
        end else begin : g_chain
            assign cin_g = g_grp[gi-1].cyv[3];
        end

        // Sum-of-products carry for each bit, from the group carry-in only.
        for (genvar j = 0; j < 4; j++) begin : g_cy
            localparam int unsigned IDX = BASE + j;
            logic [j:0] term;
            for (genvar k = 0; k <= j; k++) begin : g_term
                if (k == j) begin : g_own
                    assign term[k] = add_g[BASE+k];
                end else begin : g_prop
                    assign term[k] = add_g[BASE+k] & (&add_p[IDX:BASE+k+1]);
                end
            end
            assign cyv[j] = (|term) | ((&add_p[IDX:BASE]) & cin_g);
        end

        for (genvar j = 0; j < GSZ; j++) begin : g_sum
            if (j == 0) begin : g_s0
                assign add_sum[BASE] = add_p[BASE] ^ cin_g;
            end else begin : g_sn
                assign add_sum[BASE+j] = add_p[BASE+j] ^ cyv[j-1];
            end
        end
    end

    // Booth step result before the shift, then the shifted register images.
    logic [AW-1:0]    acc;
    logic [AW-1:0]    sh_a;
    logic [WIDTH-1:0] sh_q;

    always_comb begin
        acc  = (q_q[0] ^ qm1_q) ? add_sum : a_q;
        sh_a = {acc[AW-1], acc[AW-1:1]};
        sh_q = {acc[0], q_q[WIDTH-1:1]};
    end

    // Next-state and register updates.
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        q_d     = q_q;
        qm1_d   = qm1_q;
        m_d     = m_q;
        cnt_d   = cnt_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        prod_d  = prod_q;

        case (state_q)
            S_IDLE: begin
                if (start && !clear) begin
                    m_d     = {multiplicand[WIDTH-1], multiplicand};
                    q_d     = multiplier;
                    a_d     = '0;
                    qm1_d   = 1'b0;
                    cnt_d   = CW'(WIDTH);
                    busy_d  = 1'b1;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                if (clear) begin
                    busy_d  = 1'b0;
                    state_d = S_IDLE;
                end else begin
                    a_d   = sh_a;
                    q_d   = sh_q;
                    qm1_d = q_q[0];
                    cnt_d = cnt_q - CW'(1);
                    // Last step: publish the post-shift value in the same edge.
                    if (cnt_q == CW'(1)) begin
                        prod_d  = {sh_a[WIDTH-1:0], sh_q};
                        done_d  = 1'b1;
                        busy_d  = 1'b0;
                        state_d = S_IDLE;
                    end
                end
            end
            default: begin
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            a_q     <= '0;
            q_q     <= '0;
            qm1_q   <= 1'b0;
            m_q     <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            prod_q  <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            q_q     <= q_d;
            qm1_q   <= qm1_d;
            m_q     <= m_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            prod_q  <= prod_d;
        end
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign product = prod_q;

endmodule

// File: doc/booth_seq_mult.md
Name: booth_seq_mult

Overview:
Sequential radix-2 Booth multiplier controller for signed two's-complement operands. It owns the accumulator/multiplier shift registers and the add/subtract datapath, with carries built from 4-bit carry-lookahead groups. It sequences one add/subtract/no-op step plus an arithmetic right shift per cycle. It sits between a requesting unit, via a start/busy/done handshake, and the multiply result consumer.

Parameters:
WIDTH, 8, operand width in bits; must be a multiple of 4 and at least 4.

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
start  input  1  request; sampled only in IDLE
clear  input  1  synchronous abort; returns to IDLE, no done
multiplicand  input  WIDTH  signed operand M; sampled with start
multiplier  input  WIDTH  signed operand Q; sampled with start
busy  output  1  high while an operation is in progress
done  output  1  one-cycle completion pulse
product  output  2*WIDTH  signed result; held until the next completion

Behaviour:
- Reset (rst_n low, asynchronous): state=IDLE, busy=0, done=0, product=0, all internal registers=0. Reset mid-operation discards the operation, with no done pulse.
- Registers: A (WIDTH+1 bits, signed, sign-extended), Q (WIDTH), q_m1 (1), M (WIDTH+1, sign-extended), count (clog2(WIDTH)+1 bits).
- A is WIDTH+1 bits so that A−M cannot overflow when M = −2^(WIDTH−1).
- States: IDLE, RUN.
- IDLE:
  - done=0 except in the pulse cycle.
  - On a clock edge with start=1 and clear=0: M←sext(multiplicand), Q←multiplier, A←0, q_m1←0, count←WIDTH. Go to RUN, busy←1.
- RUN, each edge:
  - Decode {Q[0],q_m1}:
    - 01: A←A+M.
    - 10: A←A+~M+1 (subtract via carry-in 1).
    - 00/11: A unchanged.
  - Then arithmetic-shift-right {A,Q,q_m1} by 1; A MSB replicates.
  - count←count−1.
  - When the step that makes count=0 completes, at the same edge: product←{A[WIDTH−1:0],Q} taken from the post-shift value, done←1, busy←0, state←IDLE.
- Latency: start sampled at edge k gives done high for exactly the cycle following edge k+WIDTH. Product is valid from that cycle on.
- done deasserts at the next edge unconditionally.
- A start coincident with done high (state IDLE) is accepted; back-to-back throughput is one result per WIDTH cycles.
- start while busy is ignored; no queuing, and operands are not re-sampled.
- clear has priority over start and over the RUN step: state←IDLE, busy←0, done←0. product is not modified.
- Operand inputs may change freely after the start edge.
- Adder: WIDTH+1 bits. Carries come from generate/propagate per bit, grouped in 4-bit lookahead blocks and rippled between groups; the top group is sized for the extra bit. Carry-out is discarded; A wraps modulo 2^(WIDTH+1), which is exact by construction.
- Result is exact for all operand pairs, including −2^(WIDTH−1) × −2^(WIDTH−1).

Test Plan:
- WIDTH=8, 3×5: start at edge k -> busy high at edges k..k+7, done pulse after edge k+8, product=0x000F; −7×6 -> product=0xFFD6.
- Extremes: −128×−128 -> product=0x4000; −128×127 -> 0xC080; 0×−1 -> 0x0000; −1×−1 -> 0x0001.
- Start pulsed again at edges k+3 with different operands while busy -> ignored; product equals the first operation's result, and exactly one done pulse.
- Back-to-back: new start (2×−3) asserted in the done cycle of the previous op -> accepted; second done exactly 8 cycles after the first, product=0xFFFA.
- rst_n low for part of a cycle mid-RUN -> busy, done and product go to 0 immediately without a clock; after release, no done until a new start.
- clear at edge k+4 -> busy=0 next cycle, no done, product keeps its previous value. A start 2 cycles later (9×9) -> product=0x0051.
